// File: rtl/mem_arbiter_pkg.sv
// Shared widths, address type and arbiter state encoding for the shared-memory port.
package mem_arbiter_pkg;

  localparam int ARB_BUS_W  = 64;
  localparam int ARB_ADDR_W = 16;

  typedef logic [ARB_ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT_RD,
    ARB_GNT_WR
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    // The previous winner (ptr itself) is visited last, which gives the fairness.
    for (int off = 1; off <= N; off++) begin
      cand = IW'((int'(ptr) + off) % N);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NPROC processors.
// Read grants last RD_BEATS cycles (operand pair); write grants last one cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NPROC    = 4,
  parameter int BUS_W    = ARB_BUS_W,
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int RD_BEATS = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NPROC-1:0]        i_req_rd,
  input  logic [NPROC-1:0]        i_req_wr,
  input  logic [NPROC*ADDR_W-1:0] i_addr,
  input  logic [NPROC*BUS_W-1:0]  i_wdata,
  input  logic [NPROC*3-1:0]      i_wr_size,
  output logic [NPROC-1:0]        o_grant_rd,
  output logic [NPROC-1:0]        o_grant_wr,
  output logic [BUS_W-1:0]        o_rdata,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic                    o_mem_we,
  output logic [BUS_W-1:0]        o_mem_wdata,
  output logic [2:0]              o_mem_wr_size,
  input  logic [BUS_W-1:0]        i_mem_rdata
);

  localparam int IW = (NPROC > 1) ? $clog2(NPROC) : 1;
  localparam int BW = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [NPROC-1:0] eligible, pick_gnt, owner_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid, last_beat;

  logic [ADDR_W-1:0] addr_a  [NPROC];
  logic [BUS_W-1:0]  wdata_a [NPROC];
  logic [2:0]        size_a  [NPROC];

  for (genvar k = 0; k < NPROC; k++) begin : g_unpack
    assign addr_a[k]  = i_addr[k*ADDR_W +: ADDR_W];
    assign wdata_a[k] = i_wdata[k*BUS_W +: BUS_W];
    assign size_a[k]  = i_wr_size[k*3 +: 3];
  end

  assign eligible  = i_req_rd | i_req_wr;
  assign last_beat = (beat_q == BW'(RD_BEATS - 1));
  assign owner_oh  = NPROC'(1) << owner_q;

  rr_picker #(.N(NPROC), .IW(IW)) u_picker (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_d  = pick_idx;
          rr_ptr_d = pick_idx;
          // A port asserting both request types is served as a write.
          state_d  = |(pick_gnt & i_req_wr) ? ARB_GNT_WR : ARB_GNT_RD;
        end
      end
      ARB_GNT_RD: begin
        if (last_beat || !i_req_rd[owner_q]) state_d = ARB_IDLE;
        else                                 beat_d  = beat_q + 1'b1;
      end
      ARB_GNT_WR: state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Outputs decode registered state/owner only; request lines never feed grants.
  always_comb begin
    o_grant_rd    = '0;
    o_grant_wr    = '0;
    o_rdata       = '0;
    o_mem_addr    = '0;
    o_mem_we      = 1'b0;
    o_mem_wdata   = '0;
    o_mem_wr_size = '0;
    unique case (state_q)
      ARB_GNT_RD: begin
        o_grant_rd = owner_oh;
        o_mem_addr = addr_a[owner_q];
        o_rdata    = i_mem_rdata;
      end
      ARB_GNT_WR: begin
        o_grant_wr    = owner_oh;
        o_mem_we      = 1'b1;
        o_mem_addr    = addr_a[owner_q];
        o_mem_wdata   = wdata_a[owner_q];
        o_mem_wr_size = size_a[owner_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= IW'(NPROC - 1);
      beat_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared each cycle against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int NPROC = 4;
  localparam int BW    = ARB_BUS_W;
  localparam int AW    = ARB_ADDR_W;
  localparam int RDB   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NPROC-1:0]      req_rd = '0;
  logic [NPROC-1:0]      req_wr = '0;
  logic [NPROC*AW-1:0]   addr_bus = '0;
  logic [NPROC*BW-1:0]   wdata_bus = '0;
  logic [NPROC*3-1:0]    size_bus = '0;
  logic [BW-1:0]         mem_rdata = '0;
  logic [NPROC-1:0]      o_grant_rd, o_grant_wr;
  logic [BW-1:0]         o_rdata, o_mem_wdata;
  logic [AW-1:0]         o_mem_addr;
  logic                  o_mem_we;
  logic [2:0]            o_mem_wr_size;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.NPROC(NPROC), .BUS_W(BW), .ADDR_W(AW), .RD_BEATS(RDB)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_rd      (req_rd),
    .i_req_wr      (req_wr),
    .i_addr        (addr_bus),
    .i_wdata       (wdata_bus),
    .i_wr_size     (size_bus),
    .o_grant_rd    (o_grant_rd),
    .o_grant_wr    (o_grant_wr),
    .o_rdata       (o_rdata),
    .o_mem_addr    (o_mem_addr),
    .o_mem_we      (o_mem_we),
    .o_mem_wdata   (o_mem_wdata),
    .o_mem_wr_size (o_mem_wr_size),
    .i_mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_port(input int k, input logic [AW-1:0] a, input logic [BW-1:0] d,
                          input logic [2:0] s);
    addr_bus[k*AW +: AW]  = a;
    wdata_bus[k*BW +: BW] = d;
    size_bus[k*3 +: 3]    = s;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory read data changes every cycle so a stale o_rdata is caught.
  initial forever begin
    @(posedge clk);
    #1;
    mem_rdata = {$urandom, $urandom};
  end

  // Transaction-level model: who holds the port, for how long, and the round-robin pointer.
  int m_kind;   // 0 none, 1 read grant, 2 write grant
  int m_owner;
  int m_beat;
  int m_ptr;

  always @(negedge clk) begin : model_p
    logic [NPROC-1:0] e_rd, e_wr;
    logic [AW-1:0]    e_addr;
    logic [BW-1:0]    e_wdata;
    logic [2:0]       e_size;
    logic             e_we;
    int               k;
    if (rst) begin
      m_kind  = 0;
      m_owner = 0;
      m_beat  = 0;
      m_ptr   = NPROC - 1;
      check("rst_grants", {o_grant_rd, o_grant_wr}, '0);
      check("rst_we", o_mem_we, 1'b0);
      check("rst_addr", o_mem_addr, '0);
    end else begin
      e_rd = '0; e_wr = '0; e_addr = '0; e_wdata = '0; e_size = '0; e_we = 1'b0;
      if (m_kind == 1) begin
        e_rd[m_owner] = 1'b1;
        e_addr = addr_bus[m_owner*AW +: AW];
        check("m_rdata", o_rdata, mem_rdata);
      end else if (m_kind == 2) begin
        e_wr[m_owner] = 1'b1;
        e_we    = 1'b1;
        e_addr  = addr_bus[m_owner*AW +: AW];
        e_wdata = wdata_bus[m_owner*BW +: BW];
        e_size  = size_bus[m_owner*3 +: 3];
        check("m_wdata", o_mem_wdata, e_wdata);
        check("m_wr_size", o_mem_wr_size, e_size);
      end
      check("m_grant_rd", o_grant_rd, e_rd);
      check("m_grant_wr", o_grant_wr, e_wr);
      check("m_we", o_mem_we, e_we);
      check("m_addr", o_mem_addr, e_addr);
      check("m_exclusive", $countones(o_grant_rd | o_grant_wr) <= 1, 1'b1);

      if (m_kind == 0) begin
        for (int s = 1; s <= NPROC; s++) begin
          k = (m_ptr + s) % NPROC;
          if (m_kind == 0 && (req_rd[k] || req_wr[k])) begin
            m_owner = k;
            m_ptr   = k;
            m_kind  = req_wr[k] ? 2 : 1;
            m_beat  = 0;
          end
        end
      end else if (m_kind == 1) begin
        if (m_beat == RDB - 1 || !req_rd[m_owner]) m_kind = 0;
        else m_beat++;
      end else begin
        m_kind = 0;
      end
    end
  end

  logic [NPROC-1:0] exp2 [10] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                                  4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
  logic [NPROC-1:0] exp4_rd [9] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0001,
                                    4'b0001, 4'b0000, 4'b0000, 4'b0000};
  logic [NPROC-1:0] exp4_wr [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                    4'b0000, 4'b0000, 4'b0010, 4'b0000};

  initial begin
    repeat (3) next_cycle();
    check("rst_wdata", o_mem_wdata, '0);
    check("rst_size", o_mem_wr_size, 3'd0);
    rst = 1'b0;

    // Single reader on port 2, address changes between the two beats.
    req_rd = 4'b0100;
    set_port(2, 16'h0010, '0, 3'd0);
    @(negedge clk); check("t1_c0_grant", o_grant_rd, 4'b0000);
    next_cycle();
    @(negedge clk);
    check("t1_c1_grant", o_grant_rd, 4'b0100);
    check("t1_c1_addr", o_mem_addr, 16'h0010);
    check("t1_c1_rdata", o_rdata, mem_rdata);
    next_cycle();
    set_port(2, 16'h0040, '0, 3'd0);
    req_rd = '0;
    @(negedge clk);
    check("t1_c2_grant", o_grant_rd, 4'b0100);
    check("t1_c2_addr", o_mem_addr, 16'h0040);
    next_cycle();
    @(negedge clk);
    check("t1_c3_grant", o_grant_rd, 4'b0000);
    check("t1_c3_addr", o_mem_addr, 16'h0000);

    // Contention after reset: ports 0,1,3 read together.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    req_rd = 4'b1011;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) req_rd[0] = 1'b0;
      if (c == 5) req_rd[1] = 1'b0;
      if (c == 8) req_rd[3] = 1'b0;
      @(negedge clk);
      check("t2_grant_rd", o_grant_rd, exp2[c]);
      check("t2_grant_wr", o_grant_wr, 4'b0000);
      next_cycle();
    end

    // Single write from port 1.
    req_wr = 4'b0010;
    set_port(1, 16'h0080, 64'hA5A5_A5A5_A5A5_A5A5, 3'd3);
    @(negedge clk); check("t3_c0_grant", o_grant_wr, 4'b0000);
    next_cycle();
    req_wr = '0;
    @(negedge clk);
    check("t3_c1_grant", o_grant_wr, 4'b0010);
    check("t3_c1_we", o_mem_we, 1'b1);
    check("t3_c1_addr", o_mem_addr, 16'h0080);
    check("t3_c1_wdata", o_mem_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
    check("t3_c1_size", o_mem_wr_size, 3'd3);
    next_cycle();
    @(negedge clk);
    check("t3_c2_we", o_mem_we, 1'b0);
    check("t3_c2_grant", o_grant_wr, 4'b0000);

    // Port 0 read moves the pointer to 0.
    next_cycle();
    req_rd = 4'b0001;
    next_cycle();
    @(negedge clk); check("t3b_grant", o_grant_rd, 4'b0001);
    next_cycle();
    req_rd = '0;
    next_cycle();

    // Port 1 read then write, port 0 reading in between.
    req_rd = 4'b0011;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) begin req_rd[1] = 1'b0; req_wr[1] = 1'b1; end
      if (c == 5) req_rd[0] = 1'b0;
      if (c == 7) req_wr[1] = 1'b0;
      @(negedge clk);
      check("t4_grant_rd", o_grant_rd, exp4_rd[c]);
      check("t4_grant_wr", o_grant_wr, exp4_wr[c]);
      next_cycle();
    end

    // Early release: port 2 drops its read during beat 0.
    req_rd = 4'b0100;
    next_cycle();
    req_rd = '0;
    @(negedge clk); check("t5_c1_grant", o_grant_rd, 4'b0100);
    next_cycle();
    @(negedge clk); check("t5_c2_grant", o_grant_rd, 4'b0000);
    next_cycle();

    // Reset in the middle of a write grant.
    req_wr = 4'b1000;
    set_port(3, 16'h1234, 64'h0123_4567_89AB_CDEF, 3'd5);
    next_cycle();
    @(negedge clk);
    check("t6_we_before", o_mem_we, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t6_we_async", o_mem_we, 1'b0);
    check("t6_grants_async", {o_grant_rd, o_grant_wr}, '0);
    check("t6_addr_async", o_mem_addr, '0);
    next_cycle();
    rst = 1'b0;
    req_wr = '0;
    req_rd = 4'b1111;
    next_cycle();
    req_rd = '0;
    @(negedge clk); check("t6_ptr_after_rst", o_grant_rd, 4'b0001);
    next_cycle();
    @(negedge clk); check("t6_idle", o_grant_rd, 4'b0000);

    // Randomized traffic, checked by the model every cycle.
    repeat (3000) begin
      next_cycle();
      if ($urandom_range(0, 1) == 1) begin
        req_rd = NPROC'($urandom);
        req_wr = NPROC'($urandom & $urandom);
      end
      addr_bus = {$urandom, $urandom};
      for (int i = 0; i < NPROC * BW / 32; i++) wdata_bus[i*32 +: 32] = $urandom;
      for (int k = 0; k < NPROC; k++) size_bus[k*3 +: 3] = 3'($urandom_range(0, 5));
    end

    next_cycle();
    req_rd = '0;
    req_wr = '0;
    repeat (4) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares the single shared-memory port among NPROC SIMD processor instances.
- Each processor raises a read or write request. The arbiter grants one requester, routes that requester's address and write data to memory, and broadcasts read data.
- A read grant is held for RD_BEATS consecutive cycles, so a processor's two operand fetches complete back-to-back.
- Memory read is combinational: data is valid in the same cycle as the address.

Parameters:
- NPROC, 4, number of processor ports
- BUS_W, `BUS_W, data bus width
- ADDR_W, `ADDR_W, address width (width of addr_t)
- RD_BEATS, 2, cycles a read grant is held (operand pair)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_req_rd  in  NPROC  per-processor read request
- i_req_wr  in  NPROC  per-processor write request
- i_addr  in  NPROC*ADDR_W  per-processor address, port k at [k*ADDR_W +: ADDR_W]
- i_wdata  in  NPROC*BUS_W  per-processor write data
- i_wr_size  in  NPROC*3  per-processor write element count (0..5)
- o_grant_rd  out  NPROC  one-hot read grant
- o_grant_wr  out  NPROC  one-hot write grant
- o_rdata  out  BUS_W  read data, broadcast to all processors
- o_mem_addr  out  ADDR_W  shared memory address
- o_mem_we  out  1  shared memory write enable
- o_mem_wdata  out  BUS_W  shared memory write data
- o_mem_wr_size  out  3  shared memory write element count
- i_mem_rdata  in  BUS_W  shared memory read data (combinational)

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, owner=0, rr_ptr=NPROC-1, beat counter=0.
  - o_grant_rd=0, o_grant_wr=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_mem_wr_size=0.
  - Reset mid-burst drops all grants immediately; no write is issued.
- States:
  - IDLE: arbitrate. If no request, stay in IDLE.
  - GNT_RD: assert o_grant_rd[owner] for RD_BEATS cycles.
  - GNT_WR: assert o_grant_wr[owner] for 1 cycle.
- Arbitration in IDLE:
  - A port is eligible if i_req_rd[k] or i_req_wr[k] is set.
  - Pick the first eligible port searching rr_ptr+1, rr_ptr+2, ... modulo NPROC.
  - Register it as owner and set rr_ptr=owner.
  - Next state is GNT_WR if i_req_wr[owner], else GNT_RD. Write wins if a port asserts both.
- GNT_RD:
  - o_grant_rd[owner]=1.
  - o_mem_addr=i_addr[owner] (combinational mux), o_rdata=i_mem_rdata.
  - Beat counter increments each cycle; at beat RD_BEATS-1 go to IDLE.
  - If i_req_rd[owner] drops before the last beat, go to IDLE next cycle (early release).
- GNT_WR:
  - o_grant_wr[owner]=1, o_mem_we=1.
  - o_mem_addr, o_mem_wdata and o_mem_wr_size are muxed from the owner.
  - Always returns to IDLE next cycle.
- One-cycle IDLE after every grant. Processors change request type between phases, and a fresh sample prevents stale re-grants. This also guarantees fairness.
- Latency, request seen in IDLE:
  - read grant in cycles t+1..t+RD_BEATS;
  - write grant in cycle t+1.
- Grants are functions of registered state and owner only; they do not combinationally depend on i_req_*.
- o_mem_we=0 outside GNT_WR. o_mem_addr=0 in IDLE.
- Never more than one bit set across o_grant_rd|o_grant_wr.
- rr_ptr wraps from NPROC-1 to 0.

Decomposition:
- Shared package (defines/package file): arb_state_t enum {ARB_IDLE, ARB_GNT_RD, ARB_GNT_WR}. Use the existing addr_t and `BUS_W.
- Sub-module rr_picker: combinational, with inputs req vector and ptr, outputs one-hot grant and index. It is reused by the future instruction-issue arbiter.

Test Plan:
- Single reader: port 2 raises i_req_rd at cycle 0 with i_addr=0x10 then 0x40 -> o_grant_rd=4'b0100 at cycles 1 and 2; o_mem_addr=0x10 then 0x40; o_rdata tracks i_mem_rdata; IDLE at cycle 3.
- Contention: ports 0,1,3 all request read at once, rr_ptr=3 after reset -> grant order 0,1,3. Each is 2 beats, separated by 1 IDLE cycle; no overlap.
- Write: port 1 i_req_wr, addr 0x80, i_wdata=A5.., size 3 -> one cycle with o_grant_wr=4'b0010, o_mem_we=1, o_mem_addr=0x80, o_mem_wr_size=3.
- Read-then-write from same port, with port 0 also requesting -> port 1 read, IDLE, then port 0 read, then port 1 write (round-robin honoured).
- Early release: owner drops i_req_rd after beat 0 -> grant deasserts at cycle 2, IDLE at cycle 2.
- Reset mid-write: assert i_rst during GNT_WR -> o_mem_we and all grants go 0 asynchronously; after release, state=IDLE and rr_ptr=NPROC-1.
